// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Per-channel duty-level ramp controller for a bank of PWM generators.
// Accepts target levels over a valid/ready port, then walks each channel's
// level one step per STEP_CYCLES clocks toward its target. All channels
// step together, on a shared prescaler.
// Optional feature: define PWM_SEQ_IRQ_EN to add a sticky completion
// interrupt (irq_o) and its clear input (irq_clr_i).
module pwm_fade_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int STEP_CYCLES = 1000,
  parameter int MAX_LEVEL   = 9,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CH_W-1:0]       cmd_ch_i,
  input  logic [3:0]            cmd_level_i,
`ifdef PWM_SEQ_IRQ_EN
  input  logic                  irq_clr_i,
  output logic                  irq_o,
`endif
  output logic [4*NUM_CH-1:0]   duty_level_o,
  output logic [NUM_CH-1:0]     busy_o,
  output logic [NUM_CH-1:0]     done_o
);

  localparam int          PW       = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [3:0]  MAX_LVL  = 4'(MAX_LEVEL);

  logic [NUM_CH-1:0][3:0] level_q, level_d;
  logic [NUM_CH-1:0][3:0] target_q, target_d;
  logic [NUM_CH-1:0]      busy_q, busy_d;
  logic [NUM_CH-1:0]      done_q, done_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   cmd_ready_q;
  logic                   cmd_fire;
  logic                   step;
  logic [3:0]             cmd_level_clamped;

  assign cmd_fire          = cmd_valid_i & cmd_ready_q;
  assign cmd_level_clamped = (cmd_level_i > MAX_LVL) ? MAX_LVL : cmd_level_i;

  // Next-state: prescaler, per-channel step, target update, busy/done flags.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    level_d  = level_q;
    target_d = target_q;
    busy_d   = '0;
    done_d   = '0;
    step     = en_i && (|busy_q) && (presc_q == PRE_LAST);

    if (!en_i || !(|busy_q)) begin
      presc_d = '0;
    end else if (presc_q == PRE_LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    for (int n = 0; n < NUM_CH; n++) begin
      // The step always moves toward the target held before this edge.
      if (step && busy_q[n]) begin
        if (level_q[n] < target_q[n]) begin
          level_d[n] = level_q[n] + 4'd1;
        end else begin
          level_d[n] = level_q[n] - 4'd1;
        end
      end
      // Out-of-range channel indices match no channel and are dropped.
      if (cmd_fire && (cmd_ch_i == CH_W'(n))) begin
        target_d[n] = cmd_level_clamped;
      end
      busy_d[n] = (level_d[n] != target_d[n]);
      done_d[n] = step && busy_q[n] && (level_d[n] == target_d[n]);
    end
  end

  // State registers; ready rises on the first edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the per-channel level/target registers are reset explicitly
    // because a reset must abort any fade and return the PWM bank to 0.
    if (rst_i) begin
      level_q     <= '0;
      target_q    <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      presc_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      level_q     <= level_d;
      target_q    <= target_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
      cmd_ready_q <= 1'b1;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign duty_level_o = level_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef PWM_SEQ_IRQ_EN
  logic irq_q;

  // Sticky interrupt: set by any done pulse, cleared by irq_clr_i; set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else if (|done_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer
// Directed bench for pwm_fade_sequencer with NUM_CH=4, STEP_CYCLES=4.
// Expected levels are hand-derived per edge offset from the command edge.
module tb_pwm_fade_sequencer;

  localparam int NUM_CH = 4;
  localparam int STEP   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_ch_i = '0;
  logic [3:0]  cmd_level_i = '0;
  logic [15:0] duty_level_o;
  logic [3:0]  busy_o;
  logic [3:0]  done_o;
`ifdef PWM_SEQ_IRQ_EN
  logic        irq_clr_i = 1'b0;
  logic        irq_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_lvl [NUM_CH];

  pwm_fade_sequencer #(.NUM_CH(NUM_CH), .STEP_CYCLES(STEP), .MAX_LEVEL(9)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_ch_i     (cmd_ch_i),
    .cmd_level_i  (cmd_level_i),
`ifdef PWM_SEQ_IRQ_EN
    .irq_clr_i    (irq_clr_i),
    .irq_o        (irq_o),
`endif
    .duty_level_o (duty_level_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] packed_exp();
    return {exp_lvl[3], exp_lvl[2], exp_lvl[1], exp_lvl[0]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one command for exactly one edge (edge k); returns at k+1ns.
  task automatic send_cmd(input logic [1:0] ch, input logic [3:0] lvl);
    cmd_valid_i = 1'b1;
    cmd_ch_i    = ch;
    cmd_level_i = lvl;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  // Per-edge comparison of levels, busy and done against bench expectations.
  task automatic cmp_state(input string tag, input int i,
                           input logic [3:0] eb, input logic [3:0] ed);
    total++;
    if (duty_level_o !== packed_exp()) begin
      bad++;
      $display("FAIL %s levels i=%0d got=%h want=%h", tag, i, duty_level_o, packed_exp());
    end
    total++;
    if (busy_o !== eb) begin
      bad++;
      $display("FAIL %s busy i=%0d got=%b want=%b", tag, i, busy_o, eb);
    end
    total++;
    if (done_o !== ed) begin
      bad++;
      $display("FAIL %s done i=%0d got=%b want=%b", tag, i, done_o, ed);
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < NUM_CH; n++) exp_lvl[n] = 4'd0;
    #1;
    cmp_state("reset_init", 0, 4'b0000, 4'b0000);
    total++;
    if (cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_init ready got=%b want=0", cmd_ready_o);
    end
    #21 rst_i = 1'b0;   // released mid-cycle
    #1;
    total++;
    if (cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release ready_before_edge got=%b want=0", cmd_ready_o);
    end
    tick();
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release ready_after_edge got=%b want=1", cmd_ready_o);
    end
  endtask

  task automatic test_up_ramp();
    send_cmd(2'd0, 4'd3);
    cmp_state("up_ramp", 0, 4'b0001, 4'b0000);
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_lvl[0] = (i / 4 > 3) ? 4'd3 : 4'(i / 4);
      cmp_state("up_ramp", i, (i < 12) ? 4'b0001 : 4'b0000, (i == 12) ? 4'b0001 : 4'b0000);
    end
  endtask

  task automatic test_clamp_noop();
    send_cmd(2'd1, 4'd15);
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp_lvl[1] = (i / 4 > 9) ? 4'd9 : 4'(i / 4);
      cmp_state("clamp", i, (i < 36) ? 4'b0010 : 4'b0000, (i == 36) ? 4'b0010 : 4'b0000);
    end
    send_cmd(2'd1, 4'd9);
    cmp_state("noop", 0, 4'b0000, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      cmp_state("noop", i, 4'b0000, 4'b0000);
    end
  endtask

  task automatic test_retarget();
    send_cmd(2'd2, 4'd5);
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_lvl[2] = 4'(i / 4);
      cmp_state("retarget_up", i, 4'b0100, 4'b0000);
    end
    // Command lands on the same edge as the step that reaches level 2.
    send_cmd(2'd2, 4'd0);
    exp_lvl[2] = 4'd2;
    cmp_state("retarget_hit", 8, 4'b0100, 4'b0000);
    for (int i = 9; i <= 18; i++) begin
      tick();
      exp_lvl[2] = (i < 12) ? 4'd2 : (i < 16) ? 4'd1 : 4'd0;
      cmp_state("retarget_down", i, (i < 16) ? 4'b0100 : 4'b0000, (i == 16) ? 4'b0100 : 4'b0000);
    end
  endtask

  task automatic test_en_gating();
    send_cmd(2'd3, 4'd3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_lvl[3] = 4'(i / 4);
      cmp_state("en_pre", i, 4'b1000, 4'b0000);
    end
    en_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      cmp_state("en_low", i, 4'b1000, 4'b0000);
    end
    total++;
    if (dut.presc_q !== '0) begin
      bad++;
      $display("FAIL en_low prescaler got=%0d want=0", dut.presc_q);
    end
    // A command while disabled is still accepted: retarget ch3 to 4.
    send_cmd(2'd3, 4'd4);
    total++;
    if (duty_level_o[15:12] !== 4'd1 || busy_o !== 4'b1000) begin
      bad++;
      $display("FAIL en_low_cmd got_lvl=%0d got_busy=%b want_lvl=1 want_busy=1000",
               duty_level_o[15:12], busy_o);
    end
    en_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp_lvl[3] = (i < 4) ? 4'd1 : (i < 8) ? 4'd2 : (i < 12) ? 4'd3 : 4'd4;
      cmp_state("en_resume", i, (i < 12) ? 4'b1000 : 4'b0000, (i == 12) ? 4'b1000 : 4'b0000);
    end
  endtask

  task automatic test_reset_mid_fade();
    send_cmd(2'd0, 4'd9);
    for (int i = 1; i <= 5; i++) tick();
    total++;
    if (duty_level_o[3:0] !== 4'd4) begin
      bad++;
      $display("FAIL reset_mid pre_level got=%0d want=4", duty_level_o[3:0]);
    end
    #2 rst_i = 1'b1;
    #1;
    for (int n = 0; n < NUM_CH; n++) exp_lvl[n] = 4'd0;
    cmp_state("reset_async", 0, 4'b0000, 4'b0000);
    total++;
    if (cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_async ready got=%b want=0", cmd_ready_o);
    end
    tick();
    tick();
    #3 rst_i = 1'b0;
    #1;
    total++;
    if (cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid ready_before_edge got=%b want=0", cmd_ready_o);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      cmp_state("reset_after", i, 4'b0000, 4'b0000);
    end
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid ready_after got=%b want=1", cmd_ready_o);
    end
  endtask

`ifdef PWM_SEQ_IRQ_EN
  task automatic test_irq();
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_reset got=%b want=0", irq_o);
    end
    send_cmd(2'd0, 4'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (irq_o !== (i >= 5)) begin
        bad++;
        $display("FAIL irq_set i=%0d got=%b want=%b", i, irq_o, (i >= 5));
      end
    end
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear got=%b want=0", irq_o);
    end
    send_cmd(2'd0, 4'd2);
    for (int i = 1; i <= 4; i++) tick();
    total++;
    if (done_o !== 4'b0001) begin
      bad++;
      $display("FAIL irq_done got=%b want=0001", done_o);
    end
    irq_clr_i = 1'b1;
    tick();
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins got=%b want=1", irq_o);
    end
    tick();
    irq_clr_i = 1'b0;
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear2 got=%b want=0", irq_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_ramp();
    test_clamp_noop();
    test_retarget();
    test_en_gating();
    test_reset_mid_fade();
`ifdef PWM_SEQ_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
